// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register and a single-outstanding imem handshake.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
//
// state | meaning
// FETCH | request outstanding at pcF; accept, stall-buffer or redirect
// HOLD  | word returned during stall is buffered in hold_instr, no request
// DRAIN | wrong-path request still in flight at drain_addr; wait and discard
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallD,
   input  logic [1:0]  npcOp,
   input  logic [31:0] rsDataD,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instrD,
   output logic [31:0] pcD,
   output logic [31:0] pcPlus4D,
   output logic        validD,
   output logic [31:0] perfFetchCnt,
   output logic [31:0] perfSquashCnt
);

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_HOLD  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [1:0] NPC_SEQ = 2'b00;
   localparam logic [1:0] NPC_BR  = 2'b01;
   localparam logic [1:0] NPC_J   = 2'b10;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_f_q, pc_f_d;
   logic [31:0] drain_addr_q, drain_addr_d;
   logic [31:0] hold_instr_q, hold_instr_d;
   logic [31:0] instr_d_q, instr_d_d;
   logic [31:0] pc_d_q, pc_d_d;
   logic        valid_d_q, valid_d_d;

   logic        redirect;
   logic        load_valid;
   logic [31:0] pc_plus4;
   logic [31:0] br_off;
   logic [31:0] target;

   assign pc_plus4 = pc_d_q + 32'd4;
   assign br_off   = {{14{instr_d_q[15]}}, instr_d_q[15:0], 2'b00};
   assign redirect = valid_d_q & ~stallD & (npcOp != NPC_SEQ);

   always_comb begin
      target = rsDataD & ~32'h3;
      case (npcOp)
         NPC_BR:  target = pc_plus4 + br_off;
         NPC_J:   target = {pc_plus4[31:28], instr_d_q[25:0], 2'b00};
         default: target = rsDataD & ~32'h3;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      pc_f_d       = pc_f_q;
      drain_addr_d = drain_addr_q;
      hold_instr_d = hold_instr_q;
      instr_d_d    = instr_d_q;
      pc_d_d       = pc_d_q;
      valid_d_d    = valid_d_q;
      load_valid   = 1'b0;
      imem_req     = 1'b1;
      imem_addr    = pc_f_q;

      case (state_q)
         ST_FETCH: begin
            if (redirect) begin
               pc_f_d    = target;
               instr_d_d = 32'h0;
               valid_d_d = 1'b0;
               if (!imem_ready) begin
                  drain_addr_d = pc_f_q;
                  state_d      = ST_DRAIN;
               end
            end else if (imem_ready && !stallD) begin
               instr_d_d  = imem_rdata;
               pc_d_d     = pc_f_q;
               valid_d_d  = 1'b1;
               load_valid = 1'b1;
               pc_f_d     = pc_f_q + 32'd4;
            end else if (imem_ready) begin
               hold_instr_d = imem_rdata;
               state_d      = ST_HOLD;
            end else if (!stallD) begin
               instr_d_d = 32'h0;
               valid_d_d = 1'b0;
            end
         end
         ST_HOLD: begin
            imem_req = 1'b0;
            if (redirect) begin
               pc_f_d    = target;
               instr_d_d = 32'h0;
               valid_d_d = 1'b0;
               state_d   = ST_FETCH;
            end else if (!stallD) begin
               instr_d_d  = hold_instr_q;
               pc_d_d     = pc_f_q;
               valid_d_d  = 1'b1;
               load_valid = 1'b1;
               pc_f_d     = pc_f_q + 32'd4;
               state_d    = ST_FETCH;
            end
         end
         ST_DRAIN: begin
            imem_addr = drain_addr_q;
            if (!stallD) begin
               instr_d_d = 32'h0;
               valid_d_d = 1'b0;
            end
            if (imem_ready) begin
               state_d = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_FETCH;
         pc_f_q       <= RESET_PC;
         drain_addr_q <= 32'h0;
         hold_instr_q <= 32'h0;
         instr_d_q    <= 32'h0;
         pc_d_q       <= 32'h0;
         valid_d_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_f_q       <= pc_f_d;
         drain_addr_q <= drain_addr_d;
         hold_instr_q <= hold_instr_d;
         instr_d_q    <= instr_d_d;
         pc_d_q       <= pc_d_d;
         valid_d_q    <= valid_d_d;
      end
   end

   assign instrD   = instr_d_q;
   assign pcD      = pc_d_q;
   assign pcPlus4D = pc_plus4;
   assign validD   = valid_d_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
   logic [31:0] perf_squash_cnt_q, perf_squash_cnt_d;

   always_comb begin
      perf_fetch_cnt_d  = perf_fetch_cnt_q + {31'd0, load_valid};
      perf_squash_cnt_d = perf_squash_cnt_q + {31'd0, redirect};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_cnt_q  <= 32'h0;
         perf_squash_cnt_q <= 32'h0;
      end else begin
         perf_fetch_cnt_q  <= perf_fetch_cnt_d;
         perf_squash_cnt_q <= perf_squash_cnt_d;
      end
   end

   assign perfFetchCnt  = perf_fetch_cnt_q;
   assign perfSquashCnt = perf_squash_cnt_q;
`else
   logic unused_perf;
   assign unused_perf   = load_valid;
   assign perfFetchCnt  = 32'h0;
   assign perfSquashCnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall buffering, redirects, drain and reset.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        stallD;
   logic [1:0]  npcOp;
   logic [31:0] rsDataD;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instrD;
   logic [31:0] pcD;
   logic [31:0] pcPlus4D;
   logic        validD;
   logic [31:0] perfFetchCnt;
   logic [31:0] perfSquashCnt;

   logic [31:0] special_addr;
   logic [31:0] special_word;
   logic [31:0] exp_squash;
   logic [31:0] exp_fetch;

   int checks;
   int failures;

   fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .stallD        (stallD),
      .npcOp         (npcOp),
      .rsDataD       (rsDataD),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .instrD        (instrD),
      .pcD           (pcD),
      .pcPlus4D      (pcPlus4D),
      .validD        (validD),
      .perfFetchCnt  (perfFetchCnt),
      .perfSquashCnt (perfSquashCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory word is a function of address unless overridden for one address.
   always_comb begin
      if (imem_addr == special_addr) imem_rdata = special_word;
      else                           imem_rdata = 32'hA500_0000 | imem_addr;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stallD = 1'b0; npcOp = 2'b00; rsDataD = 32'h0; imem_ready = 1'b1;
      step();
      step();
      checks++; if (validD !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b required=0", validD); end
      checks++; if (instrD !== 32'h0) begin failures++; $display("FAIL reset_instr actual=%h required=00000000", instrD); end
      checks++; if (pcD !== 32'h0) begin failures++; $display("FAIL reset_pcD actual=%h required=00000000", pcD); end
      checks++; if (pcPlus4D !== 32'h4) begin failures++; $display("FAIL reset_pcplus4 actual=%h required=00000004", pcPlus4D); end
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL reset_req actual=%b required=1", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr actual=%h required=00000000", imem_addr); end
      checks++; if (perfFetchCnt !== 32'h0) begin failures++; $display("FAIL reset_fetchcnt actual=%h required=0", perfFetchCnt); end
      checks++; if (perfSquashCnt !== 32'h0) begin failures++; $display("FAIL reset_squashcnt actual=%h required=0", perfSquashCnt); end
      rst = 1'b0;
   endtask

   task automatic test_sequential();
      step();
      checks++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL seq_addr4 actual=%h required=00000004", imem_addr); end
      checks++; if (pcD !== 32'h0 || validD !== 1'b1) begin failures++; $display("FAIL seq_pcD0 actual=%h/%b required=00000000/1", pcD, validD); end
      checks++; if (instrD !== 32'hA500_0000) begin failures++; $display("FAIL seq_instr0 actual=%h required=a5000000", instrD); end
      step();
      checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL seq_addr8 actual=%h required=00000008", imem_addr); end
      checks++; if (pcD !== 32'h4 || pcPlus4D !== 32'h8) begin failures++; $display("FAIL seq_pcD4 actual=%h/%h required=00000004/00000008", pcD, pcPlus4D); end
      step();
      checks++; if (imem_addr !== 32'hC || pcD !== 32'h8) begin failures++; $display("FAIL seq_addrC actual=%h/%h required=0000000c/00000008", imem_addr, pcD); end
   endtask

   task automatic test_stall_hold();
      stallD = 1'b1;
      step();
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL hold_req1 actual=%b required=0", imem_req); end
      checks++; if (pcD !== 32'h8 || validD !== 1'b1) begin failures++; $display("FAIL hold_ifid1 actual=%h/%b required=00000008/1", pcD, validD); end
      step();
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL hold_req2 actual=%b required=0", imem_req); end
      stallD = 1'b0;
      special_addr = 32'h10; special_word = 32'h1000_0003;
      step();
      checks++; if (instrD !== 32'hA500_000C || pcD !== 32'hC) begin failures++; $display("FAIL hold_release actual=%h/%h required=a500000c/0000000c", instrD, pcD); end
      checks++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin failures++; $display("FAIL hold_norefetch actual=%h/%b required=00000010/1", imem_addr, imem_req); end
   endtask

   task automatic test_redirect();
      step();
      checks++; if (pcD !== 32'h10 || instrD !== 32'h1000_0003) begin failures++; $display("FAIL br_setup actual=%h/%h required=00000010/10000003", pcD, instrD); end
      npcOp = 2'b01;
      step();
      npcOp = 2'b00;
      checks++; if (imem_addr !== 32'h20) begin failures++; $display("FAIL br_target actual=%h required=00000020", imem_addr); end
      checks++; if (validD !== 1'b0 || instrD !== 32'h0) begin failures++; $display("FAIL br_bubble actual=%b/%h required=0/00000000", validD, instrD); end
      special_addr = 32'h24; special_word = 32'h0800_0040;
      step();
      checks++; if (pcD !== 32'h20 || validD !== 1'b1) begin failures++; $display("FAIL br_resume actual=%h/%b required=00000020/1", pcD, validD); end
      step();
      npcOp = 2'b10;
      step();
      npcOp = 2'b00;
      checks++; if (imem_addr !== 32'h100 || validD !== 1'b0) begin failures++; $display("FAIL j_target actual=%h/%b required=00000100/0", imem_addr, validD); end
      step();
      npcOp = 2'b11; rsDataD = 32'h403;
      step();
      npcOp = 2'b00;
      checks++; if (imem_addr !== 32'h400 || validD !== 1'b0) begin failures++; $display("FAIL jr_target actual=%h/%b required=00000400/0", imem_addr, validD); end
      special_addr = 32'h400; special_word = 32'h0000_FFFE;
      step();
      npcOp = 2'b01;
      step();
      npcOp = 2'b00;
      checks++; if (imem_addr !== 32'h3FC) begin failures++; $display("FAIL br_backward actual=%h required=000003fc", imem_addr); end
   endtask

   task automatic test_drain();
      rst = 1'b1; imem_ready = 1'b1;
      step();
      rst = 1'b0;
      special_addr = 32'h4; special_word = 32'h1000_0003;
      step();
      step();
      checks++; if (pcD !== 32'h4 || imem_addr !== 32'h8) begin failures++; $display("FAIL drain_setup actual=%h/%h required=00000004/00000008", pcD, imem_addr); end
      imem_ready = 1'b0; npcOp = 2'b01;
      step();
      npcOp = 2'b00;
      checks++; if (imem_addr !== 32'h8 || imem_req !== 1'b1 || validD !== 1'b0) begin failures++; $display("FAIL drain_hold0 actual=%h/%b/%b required=00000008/1/0", imem_addr, imem_req, validD); end
      step();
      checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL drain_hold1 actual=%h required=00000008", imem_addr); end
      step();
      checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL drain_hold2 actual=%h required=00000008", imem_addr); end
      imem_ready = 1'b1;
      step();
      checks++; if (imem_addr !== 32'h14 || validD !== 1'b0) begin failures++; $display("FAIL drain_exit actual=%h/%b required=00000014/0", imem_addr, validD); end
`ifdef FETCH_PERF_CNT_EN
      exp_squash = 32'd1; exp_fetch = 32'd2;
`else
      exp_squash = 32'd0; exp_fetch = 32'd0;
`endif
      checks++; if (perfSquashCnt !== exp_squash) begin failures++; $display("FAIL drain_squashcnt actual=%0d required=%0d", perfSquashCnt, exp_squash); end
      checks++; if (perfFetchCnt !== exp_fetch) begin failures++; $display("FAIL drain_fetchcnt actual=%0d required=%0d", perfFetchCnt, exp_fetch); end
      step();
      checks++; if (pcD !== 32'h14 || instrD !== 32'hA500_0014 || validD !== 1'b1) begin failures++; $display("FAIL drain_target actual=%h/%h/%b required=00000014/a5000014/1", pcD, instrD, validD); end
   endtask

   task automatic test_reset_in_drain();
      imem_ready = 1'b0; npcOp = 2'b11; rsDataD = 32'h200;
      step();
      npcOp = 2'b00;
      checks++; if (imem_addr !== 32'h18) begin failures++; $display("FAIL rdrain_enter actual=%h required=00000018", imem_addr); end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; imem_ready = 1'b1;
      checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1 || validD !== 1'b0) begin failures++; $display("FAIL rdrain_reset actual=%h/%b/%b required=00000000/1/0", imem_addr, imem_req, validD); end
      step();
      checks++; if (pcD !== 32'h0 || validD !== 1'b1 || imem_addr !== 32'h4) begin failures++; $display("FAIL rdrain_fetch actual=%h/%b/%h required=00000000/1/00000004", pcD, validD, imem_addr); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      special_addr = 32'hFFFF_FFFF;
      special_word = 32'h0;
      test_reset();
      test_sequential();
      test_stall_hold();
      test_redirect();
      test_drain();
      test_reset_in_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
